// File: rtl/am_bip_tx.sv
// Transmit alignment-marker inserter for a multi-lane 64b/66b PCS.
// Replaces one block slot per AM_PERIOD with per-lane markers that carry a running BIP.
module am_bip_tx #(
   parameter int unsigned            LANE_N      = 4,
   parameter int unsigned            HEAD_W      = 2,
   parameter int unsigned            DATA_W      = 64,
   parameter int unsigned            AM_PERIOD   = 16384,
   parameter logic [LANE_N*24-1:0]   LANE_MARKER = 96'h3D79A2_9B65C5_E6C4F0_477690
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [LANE_N*HEAD_W-1:0]   head_i,
   input  logic [LANE_N*DATA_W-1:0]   data_i,
   output logic                       valid_o,
   output logic                       marker_v_o,
   output logic [LANE_N*HEAD_W-1:0]   head_o,
   output logic [LANE_N*DATA_W-1:0]   data_o
);

   localparam int unsigned          CNT_W    = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(AM_PERIOD - 1);
   localparam logic [HEAD_W-1:0]    AM_HEAD  = HEAD_W'(2'b10);
   // A marker's bytes cancel pairwise, so only its header bit 1 survives (bit 4).
   localparam logic [7:0]           AM_SEED  = 8'h10;

   logic [CNT_W-1:0]   cnt;
   logic               marker_slot;
   logic               accept;
   logic [7:0]         bip     [LANE_N];
   logic [7:0]         blk_bip [LANE_N];
   logic [DATA_W-1:0]  mk_data [LANE_N];

   always_comb begin
      marker_slot = (cnt == CNT_LAST);
      ready_o     = ~marker_slot;
      accept      = valid_i & ~marker_slot;
   end

   // Per-lane BIP contribution of the incoming block and the marker word for this interval.
   always_comb begin
      for (int unsigned n = 0; n < LANE_N; n++) begin
         blk_bip[n] = '0;
         for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            blk_bip[n] = blk_bip[n] ^ data_i[n*DATA_W + b*8 +: 8];
         end
         blk_bip[n][3] = blk_bip[n][3] ^ head_i[n*HEAD_W];
         blk_bip[n][4] = blk_bip[n][4] ^ head_i[n*HEAD_W + 1];
         mk_data[n] = DATA_W'({~bip[n], ~LANE_MARKER[n*24 +: 24],
                               bip[n],  LANE_MARKER[n*24 +: 24]});
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt        <= '0;
         valid_o    <= 1'b0;
         marker_v_o <= 1'b0;
         head_o     <= '0;
         data_o     <= '0;
         for (int unsigned n = 0; n < LANE_N; n++) begin
            bip[n] <= '0;
         end
      end else begin
         valid_o    <= marker_slot | valid_i;
         marker_v_o <= marker_slot;
         if (marker_slot) begin
            cnt <= '0;
            for (int unsigned n = 0; n < LANE_N; n++) begin
               head_o[n*HEAD_W +: HEAD_W] <= AM_HEAD;
               data_o[n*DATA_W +: DATA_W] <= mk_data[n];
               bip[n]                     <= AM_SEED;
            end
         end else if (accept) begin
            cnt    <= cnt + CNT_W'(1);
            head_o <= head_i;
            data_o <= data_i;
            for (int unsigned n = 0; n < LANE_N; n++) begin
               bip[n] <= bip[n] ^ blk_bip[n];
            end
         end
      end
   end

endmodule

// File: tb/tb_am_bip_tx.sv
// Directed self-checking bench for am_bip_tx with AM_PERIOD=4 and the default 40G markers.
module tb_am_bip_tx;

   localparam int unsigned LANE_N = 4;
   localparam int unsigned HEAD_W = 2;
   localparam int unsigned DATA_W = 64;

   logic                      clk = 1'b0;
   logic                      nreset;
   logic                      valid_i;
   logic                      ready_o;
   logic [LANE_N*HEAD_W-1:0]  head_i;
   logic [LANE_N*DATA_W-1:0]  data_i;
   logic                      valid_o;
   logic                      marker_v_o;
   logic [LANE_N*HEAD_W-1:0]  head_o;
   logic [LANE_N*DATA_W-1:0]  data_o;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] L0_BIP08 = 64'hF7B8896F_08477690;
   localparam logic [63:0] L0_BIP18 = 64'hE7B8896F_18477690;
   localparam logic [63:0] L1_BIPF7 = 64'h08193B0F_F7E6C4F0;
   localparam logic [63:0] L2_BIP08 = 64'hF7649A3A_089B65C5;
   localparam logic [63:0] L3_BIP08 = 64'hF7C2865D_083D79A2;
   localparam logic [63:0] X_BLOCK  = 64'h01234567_89ABCDEF;

   am_bip_tx #(
      .LANE_N    (LANE_N),
      .HEAD_W    (HEAD_W),
      .DATA_W    (DATA_W),
      .AM_PERIOD (4)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .head_i     (head_i),
      .data_i     (data_i),
      .valid_o    (valid_o),
      .marker_v_o (marker_v_o),
      .head_o     (head_o),
      .data_o     (data_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic v, input logic [LANE_N*DATA_W-1:0] d, input logic [7:0] h);
      valid_i = v;
      data_i  = d;
      head_i  = h;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] lane_data(input int unsigned n);
      return data_o[n*DATA_W +: DATA_W];
   endfunction

   function automatic logic [1:0] lane_head(input int unsigned n);
      return head_o[n*HEAD_W +: HEAD_W];
   endfunction

   initial begin
      nreset  = 1'b0;
      valid_i = 1'b0;
      head_i  = '0;
      data_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_o",  64'(valid_o),    64'd0);
      chk("rst_marker_v", 64'(marker_v_o), 64'd0);
      chk("rst_head_o",   64'(head_o),     64'd0);
      chk("rst_data_l0",  lane_data(0),    64'd0);
      chk("rst_ready",    64'(ready_o),    64'd1);
      nreset = 1'b1;

      // Basic insertion: header 01, zero payload on every lane
      for (int i = 0; i < 3; i++) begin
         chk("basic_ready", 64'(ready_o), 64'd1);
         send(1'b1, '0, 8'h55);
         chk("basic_valid",  64'(valid_o),    64'd1);
         chk("basic_marker", 64'(marker_v_o), 64'd0);
         chk("basic_head",   64'(head_o),     64'h55);
      end
      chk("m1_ready", 64'(ready_o), 64'd0);
      send(1'b1, '0, 8'h55);
      chk("m1_marker", 64'(marker_v_o), 64'd1);
      chk("m1_valid",  64'(valid_o),    64'd1);
      chk("m1_head0",  64'(lane_head(0)), 64'd2);
      chk("m1_lane0",  lane_data(0), L0_BIP08);
      chk("m1_lane3",  lane_data(3), L3_BIP08);

      // BIP chaining: later markers include the previous marker's 0x10
      for (int k = 0; k < 2; k++) begin
         repeat (3) send(1'b1, '0, 8'h55);
         chk("chain_ready", 64'(ready_o), 64'd0);
         send(1'b1, '0, 8'h55);
         chk("chain_marker", 64'(marker_v_o), 64'd1);
         chk("chain_lane0",  lane_data(0), L0_BIP18);
      end

      // Stall in the marker slot, then the held block follows
      repeat (3) send(1'b1, '0, 8'h55);
      send(1'b0, {192'd0, X_BLOCK}, 8'h55);
      chk("stall_valid",  64'(valid_o),    64'd1);
      chk("stall_marker", 64'(marker_v_o), 64'd1);
      chk("stall_lane0",  lane_data(0), L0_BIP18);
      send(1'b1, {192'd0, X_BLOCK}, 8'h55);
      chk("held_valid",  64'(valid_o),    64'd1);
      chk("held_marker", 64'(marker_v_o), 64'd0);
      chk("held_lane0",  lane_data(0), X_BLOCK);
      send(1'b1, '0, 8'h55);

      // Reset after two accepted blocks
      #3 nreset = 1'b0;
      #1;
      chk("mid_rst_valid",  64'(valid_o),    64'd0);
      chk("mid_rst_marker", 64'(marker_v_o), 64'd0);
      chk("mid_rst_data0",  lane_data(0),    64'd0);
      chk("mid_rst_head",   64'(head_o),     64'd0);
      chk("mid_rst_ready",  64'(ready_o),    64'd1);
      send(1'b1, '0, 8'h55);
      nreset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_ready", 64'(ready_o), 64'd1);
         send(1'b1, '0, 8'h55);
         chk("post_rst_nomk", 64'(marker_v_o), 64'd0);
      end
      send(1'b1, '0, 8'h55);
      chk("post_rst_marker", 64'(marker_v_o), 64'd1);
      chk("post_rst_lane0",  lane_data(0), L0_BIP08);

      // Gaps: one block, five idle cycles, two blocks, then the marker
      send(1'b1, '0, 8'h55);
      for (int i = 0; i < 5; i++) begin
         chk("gap_ready", 64'(ready_o), 64'd1);
         send(1'b0, '0, 8'h55);
         chk("gap_valid", 64'(valid_o), 64'd0);
      end
      repeat (2) send(1'b1, '0, 8'h55);
      chk("gap_mk_ready", 64'(ready_o), 64'd0);
      send(1'b1, '0, 8'h55);
      chk("gap_marker", 64'(marker_v_o), 64'd1);
      chk("gap_lane0",  lane_data(0), L0_BIP18);

      // Per-lane independence from a fresh reset
      #3 nreset = 1'b0;
      #1;
      send(1'b0, '0, 8'h55);
      nreset = 1'b1;
      repeat (3) send(1'b1, {128'd0, 64'h00000000_000000FF, 64'd0}, 8'h55);
      send(1'b1, '0, 8'h55);
      chk("lane_marker", 64'(marker_v_o), 64'd1);
      chk("lane_l0",     lane_data(0), L0_BIP08);
      chk("lane_l1",     lane_data(1), L1_BIPF7);
      chk("lane_l2",     lane_data(2), L2_BIP08);
      chk("lane_l3",     lane_data(3), L3_BIP08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
